// File: rtl/aes_shiftrows_serial_unit.sv
// Byte-serial AES ShiftRows / InvShiftRows stage.
// Loads a 16-byte column-major state, then drains it in row-rotated order.
// The load/drain byte counter and the latched direction are exported for the
// downstream byte permutation controller.
module aes_shiftrows_serial_unit #(
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_left,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic [3:0]        inner_state_counter,
    output logic              shift_left_q,
    output logic              busy
);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               count_q, count_d;
    logic                     shift_left_d;
    logic [15:0][BYTE_W-1:0]  buf_q, buf_d;

    logic                     in_hs, out_hs;
    logic [1:0]               row, col, src_col;

    // Stream handshakes and output select; rst masks all handshake-visible outputs.
    always_comb begin
        in_ready  = !rst && (state_q == LOAD);
        out_valid = !rst && (state_q == DRAIN);
        busy      = out_valid;
        out_last  = out_valid && (count_q == 4'd15);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;

        // Output byte j sits at row j[1:0], column j[3:2]; the source column
        // is rotated by the row number, wrapping modulo 4 in 2 bits.
        row       = count_q[1:0];
        col       = count_q[3:2];
        src_col   = shift_left_q ? (col + row) : (col - row);
        out_data  = buf_q[{src_col, row}];

        inner_state_counter = count_q;
    end

    // Next-state: the counter is shared by both phases and wraps at 16.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shift_left_d = shift_left_q;
        buf_d        = buf_q;
        if (in_hs) begin
            buf_d[count_q] = in_data;
            count_d        = count_q + 4'd1;
            if (count_q == 4'd0)  shift_left_d = shift_left;
            if (count_q == 4'd15) state_d      = DRAIN;
        end
        if (out_hs) begin
            count_d = count_q + 4'd1;
            if (count_q == 4'd15) state_d = LOAD;
        end
    end

    // Control registers; reset returns to an empty LOAD phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            count_q      <= 4'd0;
            shift_left_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shift_left_q <= shift_left_d;
        end
    end

    // Block buffer keeps its contents across reset; writes only on accepted bytes.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_aes_shiftrows_serial_unit.sv
// Self-checking bench for aes_shiftrows_serial_unit: a behavioural state-grid
// model checked every cycle, plus literal output sequences per scenario.
module tb_aes_shiftrows_serial_unit;

    typedef logic [7:0] seq_t [16];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       shift_left = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic [3:0] inner_state_counter;
    logic       shift_left_q;
    logic       busy;

    aes_shiftrows_serial_unit #(.BYTE_W(8)) dut (
        .clk(clk), .rst(rst), .shift_left(shift_left),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .inner_state_counter(inner_state_counter),
        .shift_left_q(shift_left_q), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a block is a 4x4 grid; output grid is each row
    // rotated by its row index.
    bit         m_valid = 0;
    bit         m_drain = 0;
    int         m_cnt = 0;
    bit         m_dir = 1;
    logic [7:0] m_in [16];
    logic [7:0] m_exp [16];

    function automatic void build_expected();
        logic [7:0] g [4][4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) g[r][c] = m_in[r + 4*c];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m_exp[r + 4*c] = m_dir ? g[r][(c + r) % 4] : g[r][(c - r + 4) % 4];
    endfunction

    logic [7:0] got_q [$];
    int cyc = 0, first_ov_cyc = -100, last_in_cyc = -100, last_out_cyc = -100;
    int in_gap = -1, low_run = 0, last_low_run = 0;
    bit prev_ov = 0;

    // Compare process: check DUT against model each cycle, then advance model.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_last", out_last, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end else if (m_valid) begin
            chk("in_ready", in_ready, !m_drain);
            chk("out_valid", out_valid, m_drain);
            chk("busy", busy, m_drain);
            chk("out_last", out_last, m_drain && m_cnt == 15);
            chk("counter", inner_state_counter, m_cnt);
            chk("dir_q", shift_left_q, m_dir);
            if (m_drain) chk("out_data", out_data, m_exp[m_cnt]);
        end
        // event bookkeeping from DUT-observed handshakes
        if (out_valid && !prev_ov) first_ov_cyc = cyc;
        prev_ov = out_valid;
        if (!rst && !in_ready) low_run++;
        else if (low_run != 0) begin last_low_run = low_run; low_run = 0; end
        if (in_valid && in_ready) begin
            if (m_cnt == 0) in_gap = cyc - last_out_cyc;
            if (m_cnt == 15) last_in_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (out_last) last_out_cyc = cyc;
        end
        // model step for the coming edge
        if (rst) begin
            m_valid = 1; m_drain = 0; m_cnt = 0; m_dir = 1;
        end else if (m_valid) begin
            if (!m_drain && in_valid) begin
                if (m_cnt == 0) m_dir = shift_left;
                m_in[m_cnt] = in_data;
                if (m_cnt == 15) begin build_expected(); m_drain = 1; m_cnt = 0; end
                else m_cnt++;
            end else if (m_drain && out_ready) begin
                if (m_cnt == 15) begin m_drain = 0; m_cnt = 0; end
                else m_cnt++;
            end
        end
    end

    // Feed n bytes base+i; direction flips from byte toggle_at on; optional gaps.
    task automatic send(input logic [7:0] base, input bit dir, input int n,
                        input int toggle_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int b;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            in_valid   = 1'b1;
            in_data    = base + 8'(i);
            shift_left = (i < toggle_at) ? dir : !dir;
            b = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                b++;
                if (b > 300) begin
                    chk("in_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int b = 0;
        while (got_q.size() < n) begin
            @(posedge clk); #2;
            b++;
            if (b > 400) begin chk("out_timeout", got_q.size(), n); return; end
        end
    endtask

    task automatic chk_seq(input string nm, input int off, input seq_t e);
        n_chk++;
        if (got_q.size() < off + 16) begin
            n_fail++;
            $display("FAIL %s: got %0d bytes expected %0d", nm, got_q.size(), off + 16);
            return;
        end
        for (int i = 0; i < 16; i++)
            if (got_q[off + i] !== e[i]) begin
                n_fail++;
                $display("FAIL %s: byte %0d got %0h expected %0h", nm, i, got_q[off + i], e[i]);
                return;
            end
    endtask

    // Stall output at index 6 for three cycles, checking the held byte.
    task automatic stall_at6();
        int b = 0;
        forever begin
            @(posedge clk); #1;
            if (out_valid && inner_state_counter == 4'd6) break;
            b++;
            if (b > 500) begin chk("stall_timeout", 0, 1); return; end
        end
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", out_data, 8'h0E);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_cnt", inner_state_counter, 4'd6);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    seq_t enc  = '{8'h00,8'h05,8'h0A,8'h0F,8'h04,8'h09,8'h0E,8'h03,
                   8'h08,8'h0D,8'h02,8'h07,8'h0C,8'h01,8'h06,8'h0B};
    seq_t dec  = '{8'h00,8'h0D,8'h0A,8'h07,8'h04,8'h01,8'h0E,8'h0B,
                   8'h08,8'h05,8'h02,8'h0F,8'h0C,8'h09,8'h06,8'h03};
    seq_t enc1 = '{8'h10,8'h15,8'h1A,8'h1F,8'h14,8'h19,8'h1E,8'h13,
                   8'h18,8'h1D,8'h12,8'h17,8'h1C,8'h11,8'h16,8'h1B};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_counter", inner_state_counter, 4'd0);
        chk("reset_dir", shift_left_q, 1'b1);
        chk("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // encrypt, back-to-back
        got_q.delete();
        send(8'h00, 1'b1, 16, 16, 1'b0);
        wait_out(16);
        chk_seq("enc_seq", 0, enc);
        chk("first_out_latency", first_ov_cyc - last_in_cyc, 1);
        @(negedge clk); @(posedge clk); #1;
        chk("in_ready_low_cycles", last_low_run, 16);

        // decrypt
        got_q.delete();
        send(8'h00, 1'b0, 16, 16, 1'b0);
        wait_out(16);
        chk_seq("dec_seq", 0, dec);

        // direction toggled mid-block is ignored
        got_q.delete();
        send(8'h00, 1'b1, 16, 5, 1'b0);
        wait_out(16);
        chk_seq("toggle_seq", 0, enc);

        // random input gaps plus output stall at index 6
        got_q.delete();
        fork
            send(8'h00, 1'b1, 16, 16, 1'b1);
            stall_at6();
        join
        wait_out(16);
        chk_seq("stall_seq", 0, enc);

        // abort after 9 bytes, then a fresh block
        got_q.delete();
        send(8'h00, 1'b0, 9, 16, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h10, 1'b1, 16, 16, 1'b0);
        wait_out(16);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_count", got_q.size(), 16);
        chk_seq("abort_seq", 0, enc1);

        // two consecutive blocks, opposite directions
        got_q.delete();
        send(8'h00, 1'b1, 16, 16, 1'b0);
        send(8'h00, 1'b0, 16, 16, 1'b0);
        chk("b2b_gap", in_gap, 1);
        wait_out(32);
        chk_seq("b2b_first", 0, enc);
        chk_seq("b2b_second", 16, dec);

        // random blocks against the model
        for (int k = 0; k < 6; k++) begin
            send(8'($urandom), 1'($urandom), 16, $urandom_range(1, 16), 1'b1);
            out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            out_ready = 1'b1;
        end
        repeat (40) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
